// File: rtl/oled_frame_buffer.sv
// oled_frame_buffer
//   Double-buffered 96x64 RGB565 pixel store for one OLED panel.
//   The display driver reads the front bank through sample_pixel/pixel_index.
//   Drawing logic writes the back bank through a valid/ready port.
//   After reset both banks are filled with CLEAR_COLOUR (INIT). A clear_req
//   refills only the back bank (CLEAR). A swap_req exchanges the banks on the
//   next frame_begin that arrives while the write side is idle.
//
// Ports
//   clk           OLED pixel clock (6.25 MHz)
//   reset         asynchronous, active-high
//   frame_begin   one-cycle pulse at frame start
//   sample_pixel  one-cycle pulse, pixel_index valid
//   pixel_index   linear index x + y*WIDTH
//   pixel_data    RGB565 pixel, valid one cycle after sample_pixel, then held
//   wr_valid      draw request
//   wr_ready      write port can accept (IDLE and no clear_req)
//   wr_x, wr_y    pixel coordinates of the draw request
//   wr_colour     RGB565 value to draw
//   clear_req     fill the back bank with CLEAR_COLOUR
//   swap_req      exchange banks at the next frame_begin seen in IDLE
//   swap_pending  swap requested but not yet performed
//   busy          INIT or CLEAR in progress
//   front_sel     bank currently displayed
module oled_frame_buffer #(
  parameter int          WIDTH        = 96,
  parameter int          HEIGHT       = 64,
  parameter logic [15:0] CLEAR_COLOUR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_begin,
  input  logic        sample_pixel,
  input  logic [12:0] pixel_index,
  output logic [15:0] pixel_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [6:0]  wr_x,
  input  logic [5:0]  wr_y,
  input  logic [15:0] wr_colour,
  input  logic        clear_req,
  input  logic        swap_req,
  output logic        swap_pending,
  output logic        busy,
  output logic        front_sel
);

  localparam int          DEPTH     = WIDTH * HEIGHT;
  localparam logic [12:0] LAST_ADDR = 13'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [12:0] r_fill_cnt;
  logic [12:0] w_fill_cnt_next;
  logic        w_fill_we;
  logic        w_fill_both;

  logic        r_front_sel;
  logic        r_swap_pending;

  logic        r_out_clear;
  logic        r_out_bank;

  logic [12:0] w_pix_addr;
  logic        w_wr_in_range;
  logic        w_wr_accept;
  logic [12:0] w_mem_addr;
  logic [15:0] w_mem_data;
  logic [1:0]  w_we;

  logic        w_rd_in_range;
  logic [12:0] w_rd_addr;
  logic [15:0] w_rd_word [2];

  // y*96 + x as shifts; largest in-range result is 6143, largest raw is 6175
  assign w_pix_addr    = ({7'd0, wr_y} << 6) + ({7'd0, wr_y} << 5) + {6'd0, wr_x};
  assign w_wr_in_range = ({1'b0, wr_x} < 8'(WIDTH)) && ({2'b0, wr_y} < 8'(HEIGHT));
  // Out-of-range coordinates still complete the handshake; they just never write.
  assign w_wr_accept   = wr_valid && wr_ready && w_wr_in_range;

  // Fill has priority on the memory port; in IDLE the fill engine is off.
  assign w_mem_addr = w_fill_we ? r_fill_cnt : w_pix_addr;
  assign w_mem_data = w_fill_we ? CLEAR_COLOUR : wr_colour;

  assign w_rd_in_range = (pixel_index < 13'(DEPTH));
  assign w_rd_addr     = w_rd_in_range ? pixel_index : 13'd0;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_fill_cnt <= 13'd0;
    end else begin
      r_state    <= w_state_next;
      r_fill_cnt <= w_fill_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_fill_cnt_next = r_fill_cnt;
    w_fill_we       = 1'b0;
    w_fill_both     = 1'b0;
    busy            = 1'b1;
    wr_ready        = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_fill_we   = 1'b1;
        w_fill_both = 1'b1;
        if (r_fill_cnt == LAST_ADDR) begin
          w_state_next    = ST_IDLE;
          w_fill_cnt_next = 13'd0;
        end else begin
          w_fill_cnt_next = r_fill_cnt + 13'd1;
        end
      end
      ST_IDLE: begin
        busy     = 1'b0;
        // A clear in the same cycle wins over a write, so refuse the write.
        wr_ready = !clear_req;
        if (clear_req) begin
          w_state_next    = ST_CLEAR;
          w_fill_cnt_next = 13'd0;
        end
      end
      ST_CLEAR: begin
        w_fill_we = 1'b1;
        if (r_fill_cnt == LAST_ADDR) begin
          w_state_next    = ST_IDLE;
          w_fill_cnt_next = 13'd0;
        end else begin
          w_fill_cnt_next = r_fill_cnt + 13'd1;
        end
      end
      default: begin
        w_state_next    = ST_INIT;
        w_fill_cnt_next = 13'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bank swap: only performed when the write side is idle, so a fill never
  // straddles the displayed bank.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_front_sel    <= 1'b0;
      r_swap_pending <= 1'b0;
    end else if (frame_begin && r_swap_pending && (r_state == ST_IDLE)) begin
      r_front_sel    <= ~r_front_sel;
      r_swap_pending <= 1'b0;
    end else if (swap_req) begin
      r_swap_pending <= 1'b1;
    end
  end

  assign front_sel    = r_front_sel;
  assign swap_pending = r_swap_pending;

  // ---------------------------------------------------------------------------
  // Pixel banks: one write port (fill or draw) and one registered read port.
  // Writes use front_sel before any toggle on the same edge.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [15:0] r_mem [0:DEPTH-1];
      logic [15:0] r_rd_word;

      assign w_we[gi] = (w_fill_we && (w_fill_both || (r_front_sel != 1'(gi)))) ||
                        (w_wr_accept && (r_front_sel != 1'(gi)));

      always_ff @(posedge clk) begin
        if (w_we[gi]) begin
          r_mem[w_mem_addr] <= w_mem_data;
        end
        if (sample_pixel) begin
          r_rd_word <= r_mem[w_rd_addr];
        end
      end

      assign w_rd_word[gi] = r_rd_word;
    end
  endgenerate

  // The RAM read registers are not reset, so a small flag register forces
  // CLEAR_COLOUR after reset, during INIT and for out-of-range indices.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_clear <= 1'b1;
      r_out_bank  <= 1'b0;
    end else if (sample_pixel) begin
      r_out_clear <= (r_state == ST_INIT) || !w_rd_in_range;
      r_out_bank  <= r_front_sel;
    end
  end

  assign pixel_data = r_out_clear ? CLEAR_COLOUR : w_rd_word[r_out_bank];

endmodule

// File: tb/tb_oled_frame_buffer.sv
module tb_oled_frame_buffer;

  localparam int DEPTH   = 6144;
  localparam int M_IDLE  = 0;
  localparam int M_INIT  = 1;
  localparam int M_CLEAR = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_begin = 1'b0;
  logic        sample_pixel = 1'b0;
  logic [12:0] pixel_index = 13'd0;
  logic [15:0] pixel_data;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [6:0]  wr_x = 7'd0;
  logic [5:0]  wr_y = 6'd0;
  logic [15:0] wr_colour = 16'd0;
  logic        clear_req = 1'b0;
  logic        swap_req = 1'b0;
  logic        swap_pending;
  logic        busy;
  logic        front_sel;

  oled_frame_buffer #(
    .WIDTH(96),
    .HEIGHT(64),
    .CLEAR_COLOUR(16'h0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_begin(frame_begin),
    .sample_pixel(sample_pixel),
    .pixel_index(pixel_index),
    .pixel_data(pixel_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_x(wr_x),
    .wr_y(wr_y),
    .wr_colour(wr_colour),
    .clear_req(clear_req),
    .swap_req(swap_req),
    .swap_pending(swap_pending),
    .busy(busy),
    .front_sel(front_sel)
  );

  always #80 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: banks as plain arrays, fills treated as instantaneous
  // (reads during a fill are either forced to clear colour or hit the other
  // bank, and writes are refused, so the progressive fill is unobservable).
  // ---------------------------------------------------------------------------
  logic [15:0] m_bank [2][DEPTH];
  bit          m_front;
  bit          m_pending;
  int          m_mode;
  int          m_left;
  logic [15:0] m_pix;
  bit          m_valid = 1'b0;
  bit          mv_idle;
  int          mv_addr;

  always @(posedge clk) begin
    if (reset) begin
      m_mode    = M_INIT;
      m_left    = DEPTH;
      m_front   = 1'b0;
      m_pending = 1'b0;
      m_pix     = 16'h0000;
      for (int i = 0; i < DEPTH; i++) begin
        m_bank[0][i] = 16'h0000;
        m_bank[1][i] = 16'h0000;
      end
      m_valid = 1'b1;
    end else begin
      mv_idle = (m_mode == M_IDLE);
      if (sample_pixel) begin
        if (m_mode == M_INIT || int'(pixel_index) >= DEPTH) m_pix = 16'h0000;
        else m_pix = m_bank[m_front][pixel_index];
      end
      if (mv_idle && wr_valid && !clear_req && int'(wr_x) < 96 && int'(wr_y) < 64) begin
        mv_addr = int'(wr_y) * 96 + int'(wr_x);
        m_bank[!m_front][mv_addr] = wr_colour;
      end
      if (mv_idle && frame_begin && m_pending) begin
        m_front   = !m_front;
        m_pending = 1'b0;
      end else if (swap_req) begin
        m_pending = 1'b1;
      end
      if (mv_idle && clear_req) begin
        m_mode = M_CLEAR;
        m_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_bank[!m_front][i] = 16'h0000;
      end else if (!mv_idle) begin
        m_left--;
        if (m_left == 0) m_mode = M_IDLE;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      check("pixel_data", 32'(pixel_data), 32'(m_pix));
      check("front_sel", 32'(front_sel), 32'(m_front));
      check("swap_pending", 32'(swap_pending), 32'(m_pending));
      check("busy", 32'(busy), 32'(m_mode != M_IDLE));
      check("wr_ready", 32'(wr_ready), 32'((m_mode == M_IDLE) && !clear_req));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change just after the falling edge)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic sample_check(input int idx, input logic [15:0] exp, input string name);
    sample_pixel = 1'b1;
    pixel_index  = 13'(idx);
    step();
    sample_pixel = 1'b0;
    check(name, 32'(pixel_data), 32'(exp));
    $display("read  idx=%0d data=%h expect=%h", idx, pixel_data, exp);
  endtask

  task automatic write_px(input int x, input int y, input logic [15:0] c);
    wr_valid  = 1'b1;
    wr_x      = 7'(x);
    wr_y      = 6'(y);
    wr_colour = c;
    #1;
    check("write_ready", 32'(wr_ready), 32'd1);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    step();
    swap_req    = 1'b0;
    frame_begin = 1'b1;
    step();
    frame_begin = 1'b0;
    $display("swap  front_sel=%0d pending=%0d", front_sel, swap_pending);
  endtask

  // Counts edges until busy drops, starting from the current falling edge.
  task automatic count_busy(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (busy === 1'b1 && cnt < 8000);
  endtask

  int cnt;

  initial begin
    // 1. Reset and INIT
    repeat (3) step();
    reset = 1'b0;
    count_busy(cnt);
    check("init_len", 32'(cnt), 32'd6144);
    $display("init  cycles=%0d", cnt);
    check("init_front", 32'(front_sel), 32'd0);
    sample_check(0, 16'h0000, "init_rd0");
    sample_check(3000, 16'h0000, "init_rd3000");
    sample_check(6143, 16'h0000, "init_rd6143");

    // 2. Write then swap
    write_px(5, 2, 16'hF800);
    do_swap();
    check("swap_front", 32'(front_sel), 32'd1);
    check("swap_pend", 32'(swap_pending), 32'd0);
    sample_check(197, 16'hF800, "rd197");
    sample_check(196, 16'h0000, "rd196");

    // 3. Out-of-range accesses: x=100,y=10 would alias to index 1060
    write_px(100, 10, 16'h07E0);
    sample_check(7000, 16'h0000, "rd7000");
    do_swap();
    check("swap2_front", 32'(front_sel), 32'd0);
    sample_check(1060, 16'h0000, "rd_alias1060");

    // 4. Fill back bank, then clear with a colliding write
    for (int y = 0; y < 64; y++) begin
      for (int x = 0; x < 96; x++) begin
        wr_valid  = 1'b1;
        wr_x      = 7'(x);
        wr_y      = 6'(y);
        wr_colour = 16'h001F;
        step();
      end
    end
    wr_valid  = 1'b1;
    wr_x      = 7'd1;
    wr_y      = 6'd1;
    wr_colour = 16'h1234;
    clear_req = 1'b1;
    #1;
    check("clear_ready", 32'(wr_ready), 32'd0);
    step();
    wr_valid  = 1'b0;
    clear_req = 1'b0;
    cnt = 0;
    do begin
      swap_req    = (cnt == 100);
      frame_begin = (cnt == 100) || (cnt == 200);
      step();
      cnt++;
    end while (busy === 1'b1 && cnt < 8000);
    swap_req    = 1'b0;
    frame_begin = 1'b0;
    check("clear_len", 32'(cnt), 32'd6144);
    $display("clear cycles=%0d", cnt);
    check("clear_front", 32'(front_sel), 32'd0);
    check("clear_pend", 32'(swap_pending), 32'd1);
    frame_begin = 1'b1;
    step();
    frame_begin = 1'b0;
    check("post_clear_front", 32'(front_sel), 32'd1);
    sample_check(0, 16'h0000, "clr_rd0");
    sample_check(197, 16'h0000, "clr_rd197");
    sample_check(3000, 16'h0000, "clr_rd3000");
    sample_check(6143, 16'h0000, "clr_rd6143");

    // 5. Read latency, back-to-back samples
    write_px(0, 0, 16'hA1A1);
    write_px(1, 0, 16'hB2B2);
    write_px(2, 0, 16'hC3C3);
    do_swap();
    sample_pixel = 1'b1;
    pixel_index  = 13'd0;
    step();
    pixel_index = 13'd1;
    check("lat0", 32'(pixel_data), 32'h0000A1A1);
    step();
    pixel_index = 13'd2;
    check("lat1", 32'(pixel_data), 32'h0000B2B2);
    step();
    sample_pixel = 1'b0;
    check("lat2", 32'(pixel_data), 32'h0000C3C3);
    step();
    check("hold", 32'(pixel_data), 32'h0000C3C3);
    $display("latency samples done data=%h", pixel_data);

    // 6. Reset in the middle of CLEAR with a swap pending
    do_swap();
    check("pre6_front", 32'(front_sel), 32'd1);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    swap_req  = 1'b1;
    step();
    swap_req = 1'b0;
    repeat (2999) step();
    check("pre_rst_pend", 32'(swap_pending), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_pix", 32'(pixel_data), 32'h0000C3C3);
    reset = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_pend", 32'(swap_pending), 32'd0);
    check("rst_front", 32'(front_sel), 32'd0);
    check("rst_pix", 32'(pixel_data), 32'h00000000);
    check("rst_ready", 32'(wr_ready), 32'd0);
    $display("reset mid-clear busy=%0d front=%0d", busy, front_sel);
    step();
    step();
    reset = 1'b0;
    count_busy(cnt);
    check("reinit_len", 32'(cnt), 32'd6144);
    $display("reinit cycles=%0d", cnt);

    // 7. Randomized traffic, checked every cycle by the model
    for (int c = 0; c < 20000; c++) begin
      wr_valid  = ($urandom_range(0, 1) == 1);
      wr_x      = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(96, 127)) : 7'($urandom_range(0, 15));
      wr_y      = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 3));
      wr_colour = 16'($urandom);
      sample_pixel = ($urandom_range(0, 1) == 1);
      pixel_index  = ($urandom_range(0, 9) == 0) ? 13'($urandom_range(6000, 8191)) : 13'($urandom_range(0, 400));
      frame_begin  = ($urandom_range(0, 19) == 0);
      swap_req     = ($urandom_range(0, 14) == 0);
      clear_req    = ($urandom_range(0, 4999) == 0);
      step();
      if ((c % 2000) == 1999) $display("random batch ending cycle %0d front=%0d busy=%0d", c, front_sel, busy);
    end
    wr_valid     = 1'b0;
    sample_pixel = 1'b0;
    frame_begin  = 1'b0;
    swap_req     = 1'b0;
    clear_req    = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
